// File: rtl/x_candidate_scheduler_pkg.sv
// rtl/x_candidate_scheduler_pkg.sv - shared widths, FSM states and float helpers
// Purpose: width derivations for the candidate scheduler, its FSM state
//          encoding and an IEEE-754 double NaN test.
// Ports:   none (package).
package x_candidate_scheduler_pkg;

  // Width of one symbol index (0..A-1).
  function automatic int awidth_f(input int a);
    return $clog2(a) + 1;
  endfunction

  // Width of a digit-position counter (0..J-1).
  function automatic int jwidth_f(input int j);
    return $clog2(j) + 1;
  endfunction

  // Width of a candidate index, able to hold A^J itself.
  function automatic int nwidth_f(input int j, input int a);
    return j * $clog2(a) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Exponent all ones with a nonzero mantissa.
  function automatic logic f64_is_nan(input logic [63:0] f);
    return (&f[62:52]) && (|f[51:0]);
  endfunction

endpackage

// File: rtl/x_candidate_scheduler_base_a_odometer.sv
// rtl/x_candidate_scheduler_base_a_odometer.sv - J-digit base-A counter
// Purpose: J-digit base-A odometer; digit 0 in the LSBs increments fastest,
//          each digit wraps A-1 -> 0 and carries into the next digit.
// Ports:   clk, rst_n (async active-low), clr (sync zero), inc (advance by
//          one), digits (J*AWIDTH, digit j at [j*AWIDTH +: AWIDTH]).
module x_candidate_scheduler_base_a_odometer
  import x_candidate_scheduler_pkg::*;
#(
  parameter int J = 4,
  parameter int A = 4,
  localparam int AW = awidth_f(A)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [J*AW-1:0] digits
);

  logic [J*AW-1:0] nxt;
  logic            carry;

  // Ripple the +1 through the digits; stop at the first digit that does not wrap.
  always_comb begin
    nxt   = digits;
    carry = 1'b1;
    for (int j = 0; j < J; j++) begin
      if (carry) begin
        if (digits[j*AW +: AW] == AW'(A - 1)) begin
          nxt[j*AW +: AW] = '0;
        end else begin
          nxt[j*AW +: AW] = digits[j*AW +: AW] + AW'(1);
          carry           = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
    end else if (clr) begin
      digits <= '0;
    end else if (inc) begin
      digits <= nxt;
    end
  end

endmodule

// File: rtl/x_candidate_scheduler.sv
// rtl/x_candidate_scheduler.sv - candidate enumerator and max-F tracker
// Purpose: enumerates all A^J candidate vectors onto x/x_tvalid, paced by an
//          issue gap and an in-flight credit limit, matches returning F values
//          to candidates by order and keeps the largest non-negative F.
// Ports:   clk, rst_n (async active-low), start (pulse), x/x_tvalid (candidate
//          strobe), F_value/F_value_tvalid (results in issue order), busy,
//          done (pulse), best_x/best_F/best_idx (best candidate), spurious
//          (sticky unexpected result), timeout (sticky, watchdog build only).
// Build:   define X_SCHED_WATCHDOG_EN to add the drain watchdog and timeout port.
module x_candidate_scheduler
  import x_candidate_scheduler_pkg::*;
#(
  parameter int J         = 4,
  parameter int A         = 4,
  parameter int MAX_OUT   = 64,
  parameter int ISSUE_GAP = J,
`ifdef X_SCHED_WATCHDOG_EN
  parameter int TIMEOUT   = 4096,
`endif
  localparam int AWIDTH   = awidth_f(A),
  localparam int NWIDTH   = nwidth_f(J, A)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [J*AWIDTH-1:0] x,
  output logic                x_tvalid,
  input  logic [63:0]         F_value,
  input  logic                F_value_tvalid,
  output logic                busy,
  output logic                done,
  output logic [J*AWIDTH-1:0] best_x,
  output logic [63:0]         best_F,
  output logic [NWIDTH-1:0]   best_idx,
`ifdef X_SCHED_WATCHDOG_EN
  output logic                timeout,
`endif
  output logic                spurious
);

  localparam int TOTAL  = A ** J;
  localparam int OWIDTH = $clog2(MAX_OUT + 1);
  localparam int GWIDTH = $clog2(ISSUE_GAP + 1);

  sched_state_t       state;
  logic [NWIDTH-1:0]  issue_cnt;
  logic [NWIDTH-1:0]  recv_cnt;
  logic [OWIDTH-1:0]  outstanding;
  logic [GWIDTH-1:0]  gap_cnt;
  logic [J*AWIDTH-1:0] iss_digits;
  logic [J*AWIDTH-1:0] rcv_digits;

  logic go, can_issue, rx_ok, better;

  assign go        = start && (state == IDLE);
  assign can_issue = (state == ISSUE) && (gap_cnt == '0) &&
                     (outstanding < OWIDTH'(MAX_OUT));
  assign rx_ok     = F_value_tvalid && (outstanding != '0) &&
                     ((state == ISSUE) || (state == DRAIN));
  // Magnitude compare is only meaningful for non-negative, non-NaN doubles.
  assign better    = !F_value[63] && !f64_is_nan(F_value) &&
                     (F_value[62:0] > best_F[62:0]);

  // The receive odometer regenerates the vector of the candidate whose F
  // just arrived, so issued vectors never need to be stored.
  x_candidate_scheduler_base_a_odometer #(.J(J), .A(A)) u_iss_odo (
    .clk(clk), .rst_n(rst_n), .clr(go), .inc(can_issue), .digits(iss_digits)
  );

  x_candidate_scheduler_base_a_odometer #(.J(J), .A(A)) u_rcv_odo (
    .clk(clk), .rst_n(rst_n), .clr(go), .inc(rx_ok), .digits(rcv_digits)
  );

`ifdef X_SCHED_WATCHDOG_EN
  localparam int WWIDTH = $clog2(TIMEOUT + 1);
  logic [WWIDTH-1:0] wd_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      outstanding <= '0;
      gap_cnt     <= '0;
      x           <= '0;
      x_tvalid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      best_x      <= '0;
      best_F      <= '0;
      best_idx    <= '0;
      spurious    <= 1'b0;
`ifdef X_SCHED_WATCHDOG_EN
      wd_cnt      <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      x_tvalid <= 1'b0;
      done     <= 1'b0;

      if (F_value_tvalid && !rx_ok) begin
        spurious <= 1'b1;
      end

      if (can_issue) begin
        x         <= iss_digits;
        x_tvalid  <= 1'b1;
        issue_cnt <= issue_cnt + NWIDTH'(1);
        gap_cnt   <= GWIDTH'(ISSUE_GAP - 1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GWIDTH'(1);
      end

      case ({can_issue, rx_ok})
        2'b10:   outstanding <= outstanding + OWIDTH'(1);
        2'b01:   outstanding <= outstanding - OWIDTH'(1);
        default: outstanding <= outstanding;
      endcase

      if (rx_ok) begin
        recv_cnt <= recv_cnt + NWIDTH'(1);
        if (better) begin
          best_F   <= F_value;
          best_idx <= recv_cnt;
          best_x   <= rcv_digits;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            busy        <= 1'b1;
            best_F      <= '0;
            best_idx    <= '0;
            best_x      <= '0;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            outstanding <= '0;
            gap_cnt     <= '0;
          end
        end
        ISSUE: begin
          if (can_issue && (issue_cnt == NWIDTH'(TOTAL - 1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Move on the final result itself so done follows it by one cycle.
          if (rx_ok && (recv_cnt == NWIDTH'(TOTAL - 1))) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

`ifdef X_SCHED_WATCHDOG_EN
      if (go) begin
        wd_cnt  <= '0;
        timeout <= 1'b0;
      end else if (F_value_tvalid) begin
        wd_cnt <= '0;
      end else if (outstanding != '0) begin
        wd_cnt <= wd_cnt + WWIDTH'(1);
      end
      // A stalled evaluator: give up on the in-flight credits and finish.
      if (((state == ISSUE) || (state == DRAIN)) && (outstanding != '0) &&
          !F_value_tvalid && (wd_cnt == WWIDTH'(TIMEOUT - 1))) begin
        state       <= DONE;
        done        <= 1'b1;
        timeout     <= 1'b1;
        outstanding <= '0;
        wd_cnt      <= '0;
      end
`else
      // No watchdog: DRAIN waits for every result indefinitely.
`endif
    end
  end

endmodule

// File: tb/tb_x_candidate_scheduler.sv
// tb/tb_x_candidate_scheduler.sv - directed self-checking bench for x_candidate_scheduler
module tb_x_candidate_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] x;
  logic        x_tvalid;
  logic [63:0] F_value = '0;
  logic        F_value_tvalid = 1'b0;
  logic        busy;
  logic        done;
  logic [11:0] best_x;
  logic [63:0] best_F;
  logic [8:0]  best_idx;
  logic        spurious;
`ifdef X_SCHED_WATCHDOG_EN
  logic        timeout;
`endif

  x_candidate_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x(x), .x_tvalid(x_tvalid),
    .F_value(F_value), .F_value_tvalid(F_value_tvalid),
    .busy(busy), .done(done),
    .best_x(best_x), .best_F(best_F), .best_idx(best_idx),
`ifdef X_SCHED_WATCHDOG_EN
    .timeout(timeout),
`endif
    .spurious(spurious)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Responder / monitor state, all owned by the main initial block via tick().
  int q_idx[$];
  int q_t[$];
  int cyc = 0;
  int delay = 2;
  int kind = 0;
  bit resp_en = 1'b0;
  bit inj = 1'b0;
  int issued, returned, done_cnt, min_gap, max_out, xbad, last_iss, last_ret, done_cyc;

  function automatic logic [63:0] fmodel(input int k, input int n);
    case (k)
      0:       return (n == 137) ? 64'h3FF0000000000000 : 64'h3FE0000000000000;
      1:       return 64'h3FD0000000000000;
      default: begin
        if (n == 5) return 64'hBFF0000000000000;
        if (n == 9) return 64'h7FF8000000000001;
        return 64'h3FB0000000000000;
      end
    endcase
  endfunction

  // Digit j of candidate n is (n / 4^j) mod 4, three bits per digit.
  function automatic logic [11:0] xmodel(input int n);
    logic [11:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[j*3 +: 3] = 3'((n / (4 ** j)) % 4);
    return r;
  endfunction

  task automatic reset_stats();
    issued = 0; returned = 0; done_cnt = 0; min_gap = 1000; max_out = 0;
    xbad = 0; last_iss = -1; last_ret = -1; done_cyc = -1;
    q_idx.delete();
    q_t.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (x_tvalid) begin
      if (last_iss >= 0 && (cyc - last_iss) < min_gap) min_gap = cyc - last_iss;
      last_iss = cyc;
      if (x !== xmodel(issued)) xbad++;
      q_idx.push_back(issued);
      q_t.push_back(cyc + delay);
      issued++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (issued - returned > max_out) max_out = issued - returned;
    F_value_tvalid = 1'b0;
    if (inj) begin
      F_value_tvalid = 1'b1;
      F_value = 64'h3FF0000000000000;
      inj = 1'b0;
    end else if (resp_en && q_t.size() > 0 && q_t[0] <= cyc) begin
      F_value_tvalid = 1'b1;
      F_value = fmodel(kind, q_idx[0]);
      void'(q_idx.pop_front());
      void'(q_t.pop_front());
      returned++;
      last_ret = cyc;
    end
  endtask

  typedef struct {
    int          kind;
    int          delay;
    bit          restart;
    logic [8:0]  e_idx;
    logic [11:0] e_x;
    logic [63:0] e_F;
  } vec_t;

  vec_t vecs[4];

  task automatic run_one(input vec_t v, input string tag);
    reset_stats();
    kind = v.kind;
    delay = v.delay;
    resp_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
      start = (v.restart && i == 50) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    repeat (5) tick();
    check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " issued"}, 64'(issued), 64'd256);
    check({tag, " returned"}, 64'(returned), 64'd256);
    check({tag, " x_sequence_errors"}, 64'(xbad), 64'd0);
    check({tag, " min_gap_ge_4"}, 64'(min_gap >= 4), 64'd1);
    check({tag, " max_outstanding_le_64"}, 64'(max_out <= 64), 64'd1);
    check({tag, " done_latency"}, 64'(done_cyc - last_ret), 64'd1);
    check({tag, " best_idx"}, 64'(best_idx), 64'(v.e_idx));
    check({tag, " best_x"}, 64'(best_x), 64'(v.e_x));
    check({tag, " best_F"}, best_F, v.e_F);
    check({tag, " busy_after_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0] = '{kind: 0, delay: 2,   restart: 1'b1, e_idx: 9'd137, e_x: 12'h411, e_F: 64'h3FF0000000000000};
    vecs[1] = '{kind: 0, delay: 300, restart: 1'b0, e_idx: 9'd137, e_x: 12'h411, e_F: 64'h3FF0000000000000};
    vecs[2] = '{kind: 1, delay: 5,   restart: 1'b0, e_idx: 9'd0,   e_x: 12'h000, e_F: 64'h3FD0000000000000};
    vecs[3] = '{kind: 2, delay: 1,   restart: 1'b0, e_idx: 9'd0,   e_x: 12'h000, e_F: 64'h3FB0000000000000};

    reset_stats();
    repeat (3) tick();
    check("reset x_tvalid", 64'(x_tvalid), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset best_idx", 64'(best_idx), 64'd0);
    check("reset best_x", 64'(best_x), 64'd0);
    check("reset best_F", best_F, 64'd0);
    check("reset spurious", 64'(spurious), 64'd0);
    rst_n = 1'b1;
    tick();

    // Result with nothing outstanding while idle.
    inj = 1'b1;
    tick();
    tick();
    check("idle spurious", 64'(spurious), 64'd1);
    check("idle stays not busy", 64'(busy), 64'd0);

    for (int k = 0; k < 4; k++) run_one(vecs[k], $sformatf("vec%0d", k));

    // Reset in the middle of an enumeration, then a fresh full run.
    reset_stats();
    kind = 1;
    delay = 3;
    resp_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000 && issued < 100; i++) tick();
    check("midrst reached 100", 64'(issued), 64'd100);
    rst_n = 1'b0;
    resp_en = 1'b0;
    q_idx.delete();
    q_t.delete();
    tick();
    tick();
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst x_tvalid", 64'(x_tvalid), 64'd0);
    check("midrst best_F", best_F, 64'd0);
    check("midrst spurious", 64'(spurious), 64'd0);
    rst_n = 1'b1;
    tick();
    run_one(vecs[2], "after_reset");

`ifdef X_SCHED_WATCHDOG_EN
    begin
      int t0;
      reset_stats();
      kind = 0;
      delay = 2;
      resp_en = 1'b0;
      t0 = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8000 && done_cnt == 0; i++) tick();
      repeat (3) tick();
      check("wd done_pulses", 64'(done_cnt), 64'd1);
      check("wd timeout", 64'(timeout), 64'd1);
      check("wd issued_credit_limit", 64'(issued), 64'd64);
      check("wd waited_timeout", 64'((done_cyc - t0) >= 4096), 64'd1);
      check("wd busy", 64'(busy), 64'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
